// File: rtl/countdown_min_sec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : countdown_min_sec                                            |
// | Description : Four-digit MM:SS BCD countdown timer. Loads a clamped preset,|
// |               decrements once per TICK with a borrow chain SU->ST->MU->MT, |
// |               pulses DONE on reaching 00:00 and drives four 7-segment      |
// |               displays directly.                                           |
// | Option      : COUNTDOWN_BLINK_ON_EXPIRE_EN - blank all displays on every   |
// |               other TICK while expired.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module countdown_min_sec #(
  parameter int SEC_TENS_MAX   = 5,
  parameter int MIN_TENS_MAX   = 5,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [3:0] LOAD_MT,
  input  logic [3:0] LOAD_MU,
  input  logic [3:0] LOAD_ST,
  input  logic [3:0] LOAD_SU,
  input  logic       START,
  input  logic       PAUSE,
  output logic       RUNNING,
  output logic       DONE,
  output logic [3:0] MT,
  output logic [3:0] MU,
  output logic [3:0] ST,
  output logic [3:0] SU,
  output logic [6:0] SEG_MT,
  output logic [6:0] SEG_MU,
  output logic [6:0] SEG_ST,
  output logic [6:0] SEG_SU
);

  // FSM state encoding
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUN     = 2'd1;
  localparam logic [1:0] c_PAUSED  = 2'd2;
  localparam logic [1:0] c_EXPIRED = 2'd3;

  // Digit limits
  localparam logic [3:0] c_NINE       = 4'd9;
  localparam logic [3:0] c_ST_MAX     = 4'(SEC_TENS_MAX);
  localparam logic [3:0] c_MT_MAX     = 4'(MIN_TENS_MAX);
  localparam logic [6:0] c_SEG_INVERT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [1:0] r_state;
  logic       r_running;
  logic       r_done;
  logic [3:0] r_mt;
  logic [3:0] r_mu;
  logic [3:0] r_st;
  logic [3:0] r_su;

  logic [1:0] w_state_nxt;
  logic       w_do_dec;
  logic       w_expire;
  logic       w_count_zero;
  logic       w_count_one;
  logic       w_blank;

  logic [3:0] w_load_mt;
  logic [3:0] w_load_mu;
  logic [3:0] w_load_st;
  logic [3:0] w_load_su;

  logic       w_borrow_su;
  logic       w_borrow_st;
  logic       w_borrow_mu;
  logic [3:0] w_dec_mt;
  logic [3:0] w_dec_mu;
  logic [3:0] w_dec_st;
  logic [3:0] w_dec_su;

  // Preset clamping: units to 9, tens to their configured limits
  always_comb begin
    w_load_mt = (LOAD_MT > c_MT_MAX) ? c_MT_MAX : LOAD_MT;
    w_load_mu = (LOAD_MU > c_NINE)   ? c_NINE   : LOAD_MU;
    w_load_st = (LOAD_ST > c_ST_MAX) ? c_ST_MAX : LOAD_ST;
    w_load_su = (LOAD_SU > c_NINE)   ? c_NINE   : LOAD_SU;
  end

  assign w_count_zero = ({r_mt, r_mu, r_st, r_su} == 16'h0000);
  assign w_count_one  = ({r_mt, r_mu, r_st, r_su} == 16'h0001);

  // One-second BCD decrement; every digit resolves in the same edge
  always_comb begin
    w_borrow_su = (r_su == 4'd0);
    w_dec_su    = w_borrow_su ? c_NINE : (r_su - 4'd1);

    w_borrow_st = w_borrow_su && (r_st == 4'd0);
    if (w_borrow_su) begin
      w_dec_st = (r_st == 4'd0) ? c_ST_MAX : (r_st - 4'd1);
    end else begin
      w_dec_st = r_st;
    end

    w_borrow_mu = w_borrow_st && (r_mu == 4'd0);
    if (w_borrow_st) begin
      w_dec_mu = (r_mu == 4'd0) ? c_NINE : (r_mu - 4'd1);
    end else begin
      w_dec_mu = r_mu;
    end

    // The count expires at 00:00, so the minutes-tens digit never underflows
    w_dec_mt = w_borrow_mu ? (r_mt - 4'd1) : r_mt;
  end

  // Next-state logic with priority LOAD > PAUSE > START > TICK
  always_comb begin
    w_state_nxt = r_state;
    w_do_dec    = 1'b0;
    w_expire    = 1'b0;
    if (LOAD) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          // A zero count has nothing to count down, so START is ignored
          if (!PAUSE && START && !w_count_zero) begin
            w_state_nxt = c_RUN;
          end
        end
        c_RUN: begin
          // START has no effect while running, so a coincident TICK still counts
          if (PAUSE) begin
            w_state_nxt = c_PAUSED;
          end else if (TICK) begin
            w_do_dec = 1'b1;
            if (w_count_one) begin
              w_state_nxt = c_EXPIRED;
              w_expire    = 1'b1;
            end
          end
        end
        c_PAUSED: begin
          // Resuming consumes any coincident TICK
          if (!PAUSE && START) begin
            w_state_nxt = c_RUN;
          end
        end
        default: begin
          w_state_nxt = c_EXPIRED;
        end
      endcase
    end
  end

  // State, status flags and digit registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= c_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_mt      <= 4'd0;
      r_mu      <= 4'd0;
      r_st      <= 4'd0;
      r_su      <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == c_RUN);
      r_done    <= w_expire;
      if (LOAD) begin
        r_mt <= w_load_mt;
        r_mu <= w_load_mu;
        r_st <= w_load_st;
        r_su <= w_load_su;
      end else if (w_do_dec) begin
        r_mt <= w_dec_mt;
        r_mu <= w_dec_mu;
        r_st <= w_dec_st;
        r_su <= w_dec_su;
      end
    end
  end

`ifdef COUNTDOWN_BLINK_ON_EXPIRE_EN
  logic r_blink;

  // Blink flag toggles per TICK while expired; cleared on entry and on LOAD
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_blink <= 1'b0;
    end else if (LOAD || w_expire) begin
      r_blink <= 1'b0;
    end else if ((r_state == c_EXPIRED) && TICK) begin
      r_blink <= ~r_blink;
    end
  end

  assign w_blank = r_blink;
`else
  assign w_blank = 1'b0;
`endif

  // Active-high segment pattern {g,f,e,d,c,b,a}; codes above 9 are blanked
  function automatic logic [6:0] f_seg(input logic [3:0] digit, input logic blank);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    if (blank) begin
      pat = 7'h00;
    end
    return pat;
  endfunction

  assign SEG_MT = f_seg(r_mt, w_blank) ^ c_SEG_INVERT;
  assign SEG_MU = f_seg(r_mu, w_blank) ^ c_SEG_INVERT;
  assign SEG_ST = f_seg(r_st, w_blank) ^ c_SEG_INVERT;
  assign SEG_SU = f_seg(r_su, w_blank) ^ c_SEG_INVERT;

  assign MT      = r_mt;
  assign MU      = r_mu;
  assign ST      = r_st;
  assign SU      = r_su;
  assign RUNNING = r_running;
  assign DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_min_sec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_countdown_min_sec                                         |
// | Description : Self-checking bench for countdown_min_sec: directed vector   |
// |               table, a full-minute countdown sequence and randomized       |
// |               stimulus against a seconds-based reference model.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_countdown_min_sec;

  localparam int SEC_MAX        = 5;
  localparam int MIN_MAX        = 5;
  localparam int SEG_ACTIVE_LOW = 1;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_EXPIRED = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       TICK = 1'b0;
  logic       LOAD = 1'b0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic [3:0] LOAD_MT = 4'd0;
  logic [3:0] LOAD_MU = 4'd0;
  logic [3:0] LOAD_ST = 4'd0;
  logic [3:0] LOAD_SU = 4'd0;
  logic       RUNNING;
  logic       DONE;
  logic [3:0] MT, MU, ST, SU;
  logic [6:0] SEG_MT, SEG_MU, SEG_ST, SEG_SU;

  always #5 CLK = ~CLK;

  countdown_min_sec #(
    .SEC_TENS_MAX   (SEC_MAX),
    .MIN_TENS_MAX   (MIN_MAX),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .TICK    (TICK),
    .LOAD    (LOAD),
    .LOAD_MT (LOAD_MT),
    .LOAD_MU (LOAD_MU),
    .LOAD_ST (LOAD_ST),
    .LOAD_SU (LOAD_SU),
    .START   (START),
    .PAUSE   (PAUSE),
    .RUNNING (RUNNING),
    .DONE    (DONE),
    .MT      (MT),
    .MU      (MU),
    .ST      (ST),
    .SU      (SU),
    .SEG_MT  (SEG_MT),
    .SEG_MU  (SEG_MU),
    .SEG_ST  (SEG_ST),
    .SEG_SU  (SEG_SU)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the count is held as total seconds
  int m_secs  = 0;
  int m_state = M_IDLE;
  bit m_done  = 1'b0;
  bit m_blink = 1'b0;

  typedef struct {
    bit          rst_n;
    bit          load;
    logic [15:0] ld;
    bit          start;
    bit          pause;
    bit          tick;
    logic [15:0] exp_cnt;
    bit          exp_run;
    bit          exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst_n, bit load, logic [15:0] ld, bit start, bit pause,
                              bit tick, logic [15:0] exp_cnt, bit exp_run, bit exp_done);
    vec_t v;
    v.rst_n = rst_n; v.load = load; v.ld = ld; v.start = start; v.pause = pause;
    v.tick = tick; v.exp_cnt = exp_cnt; v.exp_run = exp_run; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] model_bcd();
    int mins;
    int secs;
    mins = m_secs / 60;
    secs = m_secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] d, input bit blank);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
      4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
      4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  default: p = 7'h00;
    endcase
    if (blank) p = 7'h00;
    if (SEG_ACTIVE_LOW != 0) p = ~p;
    return p;
  endfunction

  function automatic logic [27:0] exp_segs(input logic [15:0] cnt, input bit blank);
    return {exp_seg(cnt[15:12], blank), exp_seg(cnt[11:8], blank),
            exp_seg(cnt[7:4], blank), exp_seg(cnt[3:0], blank)};
  endfunction

  task automatic model_step(input bit rst_n, input bit load, input logic [15:0] ld,
                            input bit start, input bit pause, input bit tick);
    bit nd;
    nd = 1'b0;
    if (!rst_n) begin
      m_secs = 0; m_state = M_IDLE; m_blink = 1'b0;
    end else if (load) begin
      m_secs = (clampi(int'(ld[15:12]), MIN_MAX) * 10 + clampi(int'(ld[11:8]), 9)) * 60
             + clampi(int'(ld[7:4]), SEC_MAX) * 10 + clampi(int'(ld[3:0]), 9);
      m_state = M_IDLE; m_blink = 1'b0;
    end else begin
      case (m_state)
        M_IDLE:   if (!pause && start && m_secs != 0) m_state = M_RUN;
        M_RUN: begin
          if (pause) m_state = M_PAUSED;
          else if (tick) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_state = M_EXPIRED; nd = 1'b1; m_blink = 1'b0;
            end
          end
        end
        M_PAUSED: if (!pause && start) m_state = M_RUN;
        default: begin
`ifdef COUNTDOWN_BLINK_ON_EXPIRE_EN
          if (tick) m_blink = ~m_blink;
`endif
        end
      endcase
    end
    m_done = nd;
  endtask

  task automatic apply(input bit rst_n, input bit load, input logic [15:0] ld,
                       input bit start, input bit pause, input bit tick);
    @(negedge CLK);
    RST_N = rst_n; LOAD = load; START = start; PAUSE = pause; TICK = tick;
    {LOAD_MT, LOAD_MU, LOAD_ST, LOAD_SU} = ld;
    @(posedge CLK);
    model_step(rst_n, load, ld, start, pause, tick);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " digits"}, {16'h0, MT, MU, ST, SU}, {16'h0, model_bcd()});
    chk({tag, " running"}, {31'h0, RUNNING}, {31'h0, (m_state == M_RUN)});
    chk({tag, " done"}, {31'h0, DONE}, {31'h0, m_done});
    chk({tag, " segs"}, {4'h0, SEG_MT, SEG_MU, SEG_ST, SEG_SU},
        {4'h0, exp_segs(model_bcd(), m_blink)});
  endtask

  initial begin
    int done_pulses;
    logic [15:0] ld;

    // rst, load, preset, start, pause, tick, expected count, running, done
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0059, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0959, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 16'h0959, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0959, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 16'h0959, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0958, 1, 0));
    vecs.push_back(mk(1, 1, 16'h7C83, 0, 0, 0, 16'h5953, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0030, 0, 0, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0030, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0029, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'hFFFF, 0, 0, 0, 16'h5959, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h5959, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0045, 0, 0, 1, 16'h0045, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 16'h0045, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 16'h0045, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0044, 1, 0));

    // Directed vector table
    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].load, vecs[i].ld, vecs[i].start, vecs[i].pause, vecs[i].tick);
      chk($sformatf("vec%0d digits", i), {16'h0, MT, MU, ST, SU}, {16'h0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d running", i), {31'h0, RUNNING}, {31'h0, vecs[i].exp_run});
      chk($sformatf("vec%0d done", i), {31'h0, DONE}, {31'h0, vecs[i].exp_done});
      chk($sformatf("vec%0d segs", i), {4'h0, SEG_MT, SEG_MU, SEG_ST, SEG_SU},
          {4'h0, exp_segs(vecs[i].exp_cnt, m_blink)});
    end

    // Full minute countdown: DONE must pulse exactly once, at 00:00
    done_pulses = 0;
    apply(1, 1, 16'h0100, 0, 0, 0);
    apply(1, 0, 16'h0000, 1, 0, 0);
    for (int k = 0; k < 62; k++) begin
      apply(1, 0, 16'h0000, 0, 0, 1);
      check_model($sformatf("minute%0d", k));
      if (DONE) done_pulses++;
    end
    chk("minute done pulses", 32'(done_pulses), 32'd1);
    chk("minute final count", {16'h0, MT, MU, ST, SU}, 32'h0);

    // Randomized stimulus against the reference model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ld = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      end else begin
        ld = 16'($urandom);
      end
      apply($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0, ld,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1);
      check_model($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
